// File: rtl/fetch_pkg.sv
// Shared constants and types for the nibble-CPU fetch sequencer.
package fetch_pkg;

    localparam int DEFAULT_INSTR_W     = 4;
    localparam int DEFAULT_OPRND_W     = 4;
    localparam int DEFAULT_STACK_DEPTH = 4;

    // Program counter reset value.
    localparam int PC_RESET = 0;

    // The PC spans an operand nibble plus a whole program byte.
    function automatic int calcPcW(input int instrW, input int oprndW);
        return oprndW + instrW + oprndW;
    endfunction

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO for the fetch sequencer.
// The pointer counts stored entries (0 = empty). Entry storage is not reset.
module ret_stack
    import fetch_pkg::*;
#(
    parameter int PC_W        = calcPcW(DEFAULT_INSTR_W, DEFAULT_OPRND_W),
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] pushData,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] top
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  entries [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] rdIdx;

    // Status flags and entry addressing derived from the pointer.
    always_comb begin
        full  = (sp == SP_W'(STACK_DEPTH));
        empty = (sp == '0);
        wrIdx = IDX_W'(sp);
        rdIdx = IDX_W'(sp - SP_W'(1));
        top   = entries[rdIdx];
    end

    // Pointer moves up on an accepted push, down on an accepted pop; push wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Write the pushed return address into the next free slot.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            entries[wrIdx] <= pushData;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-control unit: PC, fetch/execute phase, instruction/operand latch.
// Optional return stack (call/ret/stack_err) enabled by FETCH_RET_STACK_EN;
// without it call acts as load_pc, ret only as inc_pc, stack_err is 0.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter  int INSTR_W     = DEFAULT_INSTR_W,
    parameter  int OPRND_W     = DEFAULT_OPRND_W,
    parameter  int STACK_DEPTH = DEFAULT_STACK_DEPTH,
    localparam int BYTE_W      = INSTR_W + OPRND_W,
    localparam int PC_W        = calcPcW(INSTR_W, OPRND_W)
)(
    input  logic               clock,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  program_byte,
    input  logic               hold,
    input  logic               inc_pc,
    input  logic               load_pc,
    input  logic               call,
    input  logic               ret,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    target,
    output logic [INSTR_W-1:0] instr,
    output logic [OPRND_W-1:0] oprnd,
    output logic               phase,
    output logic               stack_err
);

    if (STACK_DEPTH < 1) begin : gBadDepth
        $error("fetch_sequencer: STACK_DEPTH must be at least 1");
    end

    phase_e          phaseState;
    phase_e          phaseNext;
    logic            execPhase;
    logic [PC_W-1:0] pcNext;
    logic [PC_W-1:0] pcPlusOne;

    assign phase = phaseState;

    // Jump target, sequential successor and phase decode.
    always_comb begin
        target    = {oprnd, program_byte};
        pcPlusOne = PC + PC_W'(1);
        execPhase = (phaseState == PH_EXEC);
    end

    // Phase register: fetch/execute alternate on every unstalled edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phaseState <= PH_FETCH;
        end else begin
            phaseState <= phaseNext;
        end
    end

    // Next phase: toggle unless stalled.
    always_comb begin
        phaseNext = phaseState;
        if (!hold) begin
            case (phaseState)
                PH_FETCH: phaseNext = PH_EXEC;
                PH_EXEC:  phaseNext = PH_FETCH;
                default:  phaseNext = PH_FETCH;
            endcase
        end
    end

    // PC register plus instruction/operand capture during fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PC    <= PC_W'(PC_RESET);
            instr <= '0;
            oprnd <= '0;
        end else begin
            PC <= pcNext;
            if (!hold && (phaseState == PH_FETCH)) begin
                instr <= program_byte[BYTE_W-1:OPRND_W];
                oprnd <= program_byte[OPRND_W-1:0];
            end
        end
    end

`ifdef FETCH_RET_STACK_EN

    logic            stackPush;
    logic            stackPop;
    logic            stackFull;
    logic            stackEmpty;
    logic [PC_W-1:0] stackTop;
    logic            errSet;
    logic            errReg;

    // PC selection with stack control: load > call > ret > inc > hold.
    // Flow control is only honoured in execute; fetch sees inc_pc alone.
    always_comb begin
        pcNext    = PC;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        errSet    = 1'b0;
        if (!hold) begin
            if (execPhase && load_pc) begin
                pcNext = target;
            end else if (execPhase && call) begin
                pcNext = target;
                if (stackFull) begin
                    errSet = 1'b1;
                end else begin
                    stackPush = 1'b1;
                end
            end else if (execPhase && ret) begin
                if (stackEmpty) begin
                    pcNext = pcPlusOne;
                    errSet = 1'b1;
                end else begin
                    pcNext   = stackTop;
                    stackPop = 1'b1;
                end
            end else if (inc_pc) begin
                pcNext = pcPlusOne;
            end
        end
    end

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) uRetStack (
        .clock    (clock),
        .reset    (reset),
        .push     (stackPush),
        .pop      (stackPop),
        .pushData (pcPlusOne),
        .full     (stackFull),
        .empty    (stackEmpty),
        .top      (stackTop)
    );

    // Sticky stack error: set on overflow or underflow, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            errReg <= 1'b0;
        end else if (errSet) begin
            errReg <= 1'b1;
        end
    end

    assign stack_err = errReg;

`else

    // PC selection without a stack: call aliases load_pc, ret only rides on inc_pc.
    always_comb begin
        pcNext = PC;
        if (!hold) begin
            if (execPhase && (load_pc || call)) begin
                pcNext = target;
            end else if (inc_pc || (execPhase && ret && inc_pc)) begin
                pcNext = pcPlusOne;
            end
        end
    end

    assign stack_err = 1'b0;

`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random traffic.
module tb_fetch_sequencer;

    localparam int PC_W  = 12;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << PC_W;

    logic        clock;
    logic        reset;
    logic [7:0]  program_byte;
    logic        hold;
    logic        inc_pc;
    logic        load_pc;
    logic        call;
    logic        ret;
    logic [11:0] PC;
    logic [11:0] target;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        stack_err;

    fetch_sequencer #(
        .INSTR_W     (4),
        .OPRND_W     (4),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .program_byte (program_byte),
        .hold         (hold),
        .inc_pc       (inc_pc),
        .load_pc      (load_pc),
        .call         (call),
        .ret          (ret),
        .PC           (PC),
        .target       (target),
        .instr        (instr),
        .oprnd        (oprnd),
        .phase        (phase),
        .stack_err    (stack_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int pc;
        int ph;
        int ins;
        int opr;
        int err;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int mPc, mPh, mIns, mOpr, mErr;
    int mStack[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void modelReset();
        mPc = 0; mPh = 0; mIns = 0; mOpr = 0; mErr = 0;
        mStack.delete();
    endfunction

    function automatic void modelStep();
        int tgt;
        int nxt;
        if (hold) return;
        tgt = mOpr * 256 + int'(program_byte);
        nxt = mPc;
`ifdef FETCH_RET_STACK_EN
        if (mPh == 1 && load_pc) nxt = tgt;
        else if (mPh == 1 && call) begin
            if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % MOD);
            else mErr = 1;
            nxt = tgt;
        end else if (mPh == 1 && ret) begin
            if (mStack.size() == 0) begin
                nxt  = (mPc + 1) % MOD;
                mErr = 1;
            end else begin
                nxt = mStack.pop_back();
            end
        end else if (inc_pc) nxt = (mPc + 1) % MOD;
`else
        if (mPh == 1 && (load_pc || call)) nxt = tgt;
        else if (inc_pc) nxt = (mPc + 1) % MOD;
`endif
        if (mPh == 0) begin
            mIns = int'(program_byte) / 16;
            mOpr = int'(program_byte) % 16;
        end
        mPh = 1 - mPh;
        mPc = nxt;
    endfunction

    // Apply inputs, let one edge happen, record what the model predicts.
    task automatic doCycle(input logic h, input logic i, input logic l,
                           input logic c, input logic r, input logic [7:0] b);
        exp_t e;
        hold = h; inc_pc = i; load_pc = l; call = c; ret = r; program_byte = b;
        @(posedge clock);
        modelStep();
        e.pc = mPc; e.ph = mPh; e.ins = mIns; e.opr = mOpr; e.err = mErr;
        expQ.push_back(e);
        #2;
    endtask

    // Asynchronous reset pulse placed between edges, after the monitor sample.
    task automatic pulseReset();
        #4;
        reset = 1'b1;
        #1;
        modelReset();
        check("rst_async_pc", int'(PC), 0);
        check("rst_async_phase", int'(phase), 0);
        check("rst_async_instr", int'(instr), 0);
        check("rst_async_oprnd", int'(oprnd), 0);
        check("rst_async_err", int'(stack_err), 0);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every falling edge compares the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("sb_pc", int'(PC), e.pc);
                check("sb_phase", int'(phase), e.ph);
                check("sb_instr", int'(instr), e.ins);
                check("sb_oprnd", int'(oprnd), e.opr);
                check("sb_err", int'(stack_err), e.err);
                check("sb_target", int'(target), e.opr * 256 + int'(program_byte));
            end
        end
    end

    initial begin
        int holdPc;
`ifdef FETCH_RET_STACK_EN
        localparam bit STK = 1'b1;
`else
        localparam bit STK = 1'b0;
`endif
        reset = 1'b1;
        hold = 0; inc_pc = 0; load_pc = 0; call = 0; ret = 0; program_byte = 8'h00;
        modelReset();
        #27;
        reset = 1'b0;
        check("reset_pc", int'(PC), 0);
        check("reset_phase", int'(phase), 0);
        check("reset_instr", int'(instr), 0);
        check("reset_err", int'(stack_err), 0);

        // First fetch after release, then plain incrementing
        doCycle(0, 1, 0, 0, 0, 8'hA5);
        check("t1_instr", int'(instr), 'hA);
        check("t1_oprnd", int'(oprnd), 'h5);
        check("t1_phase", int'(phase), 1);
        check("t1_pc", int'(PC), 1);
        for (int k = 0; k < 3; k++) doCycle(0, 1, 0, 0, 0, 8'hA5);
        check("t1_pc4", int'(PC), 4);
        check("t1_phase4", int'(phase), 0);

        // load_pc beats inc_pc in execute
        doCycle(0, 1, 0, 0, 0, 8'h43);
        doCycle(0, 1, 1, 0, 0, 8'h21);
        check("load_321", int'(PC), 'h321);

        // Wrap at the top of the address space
        doCycle(0, 1, 0, 0, 0, 8'h0F);
        doCycle(0, 1, 1, 0, 0, 8'hFF);
        check("load_fff", int'(PC), 'hFFF);
        doCycle(0, 1, 0, 0, 0, 8'h00);
        check("wrap_pc", int'(PC), 0);
        check("wrap_err", int'(stack_err), 0);
        doCycle(0, 1, 0, 0, 0, 8'h00);

        // Call from 0x010 to 0x200, then return
        doCycle(0, 1, 0, 0, 0, 8'h00);
        doCycle(0, 0, 1, 0, 0, 8'h0F);
        doCycle(0, 1, 0, 0, 0, 8'h02);
        check("pre_call_pc", int'(PC), 'h010);
        doCycle(0, 0, 0, 1, 0, 8'h00);
        check("call_pc", int'(PC), 'h200);
        doCycle(0, 1, 0, 0, 0, 8'h00);
        doCycle(0, 0, 0, 0, 1, 8'h00);
        check("ret_pc", int'(PC), STK ? 'h011 : 'h201);

        // Five nested calls overflow a four-entry stack
        for (int k = 1; k <= 5; k++) begin
            doCycle(0, 1, 0, 0, 0, 8'h03);
            doCycle(0, 0, 0, 1, 0, 8'(k * 16));
            if (k == 4) check("nest4_err", int'(stack_err), 0);
        end
        check("nest5_err", int'(stack_err), STK ? 1 : 0);
        check("nest5_pc", int'(PC), 'h350);

        // Asynchronous reset mid-execute at PC=0x123
        doCycle(0, 1, 0, 0, 0, 8'h01);
        doCycle(0, 0, 1, 0, 0, 8'h22);
        doCycle(0, 1, 0, 0, 0, 8'h00);
        check("pre_rst_pc", int'(PC), 'h123);
        check("pre_rst_phase", int'(phase), 1);
        pulseReset();

        // Return on an empty stack
        doCycle(0, 1, 0, 0, 0, 8'h00);
        doCycle(0, 0, 0, 0, 1, 8'h00);
        check("ret_empty_pc", int'(PC), STK ? 2 : 1);
        check("ret_empty_err", int'(stack_err), STK ? 1 : 0);

        // Three stalled edges freeze everything
        holdPc = STK ? 2 : 1;
        for (int k = 0; k < 3; k++) begin
            doCycle(1, 1, 1, 0, 0, 8'h77);
            check("hold_pc", int'(PC), holdPc);
            check("hold_phase", int'(phase), 0);
            check("hold_instr", int'(instr), 0);
        end
        doCycle(0, 1, 0, 0, 0, 8'h77);
        check("resume_pc", int'(PC), holdPc + 1);
        check("resume_instr", int'(instr), 7);
        check("resume_phase", int'(phase), 1);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic h, i, l, c, r;
            logic [7:0] b;
            if ($urandom_range(0, 99) < 2) pulseReset();
            h = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 6) == 0);
            r = ($urandom_range(0, 5) == 0);
            b = 8'($urandom);
            doCycle(h, i, l, c, r, b);
        end

        #10;
        check("scoreboard_drain", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised program-control unit for the nibble-CPU family.
- Holds the program counter and the fetch/execute phase toggle.
- Latches the instruction and operand fields of each fetched program byte.
- Adds stall, call/return with a hardware return stack, and an error flag; decode logic drives it and program ROM feeds it.

Parameters:
- INSTR_W, 4, opcode field width (upper bits of the program byte).
- OPRND_W, 4, operand field width (lower bits of the program byte).
- STACK_DEPTH, 4, return-stack entries; must be at least 1, need not be a power of two.
- Derived localparams: BYTE_W = INSTR_W+OPRND_W; PC_W = OPRND_W+BYTE_W (default 12).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- program_byte  in  BYTE_W  ROM data at address PC.
- hold  in  1  stall: freezes PC, phase, instr, oprnd and stack.
- inc_pc  in  1  advance PC by 1.
- load_pc  in  1  jump to target {oprnd, program_byte}.
- call  in  1  push return address, then jump to target.
- ret  in  1  pop the return address into PC.
- PC  out  PC_W  program counter / ROM address.
- target  out  PC_W  {oprnd, program_byte}, combinational.
- instr  out  INSTR_W  latched opcode.
- oprnd  out  OPRND_W  latched operand.
- phase  out  1  0 = fetch, 1 = execute.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, immediate): PC=0, phase=0, instr=0, oprnd=0, stack pointer=0 (empty), stack_err=0. Stack contents are don't-care.
- Phase: toggles every rising edge unless hold=1.
- Fetch latch: on an edge with phase=0 and hold=0, instr<=program_byte[BYTE_W-1:OPRND_W] and oprnd<=program_byte[OPRND_W-1:0]. Fields are otherwise held. Outputs are valid from the edge that sets phase=1.
- PC update on each edge with hold=0. Priority: load_pc > call > ret > inc_pc > hold value.
- load_pc, call and ret are honoured only when phase=1; when phase=0 they are ignored and inc_pc alone applies. inc_pc is honoured in either phase.
- All PC arithmetic is modulo 2^PC_W: 0xFFF+1 -> 0x000 at default widths.
- call: push (PC+1) mod 2^PC_W and load target in the same edge.
  - If the stack is full: push discarded, stack_err<=1, jump still taken.
- ret: PC<=top entry and pop.
  - If the stack is empty: PC<=PC+1, stack_err<=1, pointer stays 0.
- Simultaneous call+ret: call wins; ret is ignored.
- Simultaneous load_pc+call: load only, no push.
- Latency: 1 edge from request to new PC; the ROM byte follows combinationally.
- stack_err clears only on reset.
- Reset asserted mid-operation: all state is cleared at once, independent of clock and hold. Execution restarts with a fetch at PC=0 on the first edge after release.

Optional Feature:
- Macro: FETCH_RET_STACK_EN.
- Defined: return stack, call, ret and stack_err behave as above.
- Undefined:
  - No stack storage is built.
  - call behaves exactly as load_pc.
  - ret behaves exactly as inc_pc, but only when inc_pc is also asserted; otherwise it is ignored.
  - stack_err is tied to 0.

Decomposition:
- Package fetch_pkg: default INSTR_W/OPRND_W/STACK_DEPTH constants; a PC_W computation function; a PC_RESET constant (0).
- Sub-module ret_stack: LIFO with push/pop/full/empty/top, parametrised by width PC_W and STACK_DEPTH. Instantiated only under FETCH_RET_STACK_EN.

Test Plan:
- Reset release, program_byte=0xA5, inc_pc=1 held -> edge 1: instr=0xA, oprnd=0x5, phase=1, PC=1; PC increments every edge thereafter; phase alternates.
- Execute phase: oprnd=0x3, program_byte=0x21, load_pc=1 and inc_pc=1 together -> PC=0x321.
- PC=0xFFF, inc_pc=1 -> PC=0x000, no error.
- Call at PC=0x010 with target 0x200 -> PC=0x200. Later ret in phase=1 -> PC=0x011. With STACK_DEPTH=4, five nested calls -> stack_err=1 on the fifth while the jump is still taken. Ret on an empty stack -> PC+1, stack_err=1.
- hold=1 for 3 edges mid-program -> PC, phase, instr and oprnd unchanged; resumes identically after hold drops.
- Reset pulsed asynchronously between edges while PC=0x123 and phase=1 -> outputs are 0 immediately, stack_err=0.
